xc_aesmix_ctrl: RTL and testbench
=================================

XC_AESMIX_CTRL -- requirements
Module: xc_aesmix_ctrl

Interface
REQ-001 The block SHALL have parameter-free ports, with one macro defined under Configuration.
REQ-002 clock  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (reset=0 resets).
REQ-004 flush  in  1  synchronous abort of any operation in progress.
REQ-005 in_valid  in  1  request carries a valid AES state.
REQ-006 in_ready  out  1  block can accept a request this cycle.
REQ-007 in_enc  in  1  1=forward MixColumns, 0=InvMixColumns; sampled on accept.
REQ-008 in_state  in  128  AES state: column c = in_state[32c+31:32c], byte r of a column = bits [8r+7:8r].
REQ-009 out_valid  out  1  result is available and stable.
REQ-010 out_ready  in  1  consumer accepts the result.
REQ-011 out_state  out  128  mixed state, using the same column and byte layout as in_state.
REQ-012 busy  out  1  high in RUN and DONE.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE, with a 2-bit column counter col.
REQ-014 in_ready SHALL be 1 only in IDLE with flush=0.
REQ-015 Accept: in_valid & in_ready -> latch in_state and in_enc into internal registers, clear col to 0, and move to RUN.
REQ-016 In RUN, each cycle SHALL pass column col through one shared xc_aesmix instance:
  - rs1=rs2=column word, enc=latched enc, valid=1.
  - The resulting 32-bit word SHALL be written into column col of the result register.
  - col SHALL then increment.
REQ-017 RUN with col==3 SHALL move to DONE after writing column 3.
REQ-018 Latency: accept on edge T -> out_valid high from edge T+4 (four RUN cycles); throughput is one state per 5 cycles minimum.
REQ-019 In DONE, out_valid=1 and out_state SHALL hold constant until out_valid & out_ready.
REQ-020 On the DONE handshake the FSM SHALL return to IDLE, and in_ready SHALL rise the following cycle (no same-cycle re-accept).
REQ-021 out_valid SHALL never be asserted outside DONE.
REQ-022 flush=1 in any state SHALL force IDLE and col=0 on the next edge, drop out_valid, and discard the partial result.
REQ-023 flush SHALL take priority over accept and over the output handshake in the same cycle.
REQ-024 in_valid while not in IDLE SHALL be ignored; the latched state SHALL not change.
REQ-025 The xc_aesmix valid input SHALL be 0 outside RUN, so its operands are gated to zero.
REQ-026 out_state SHALL hold the previous result register contents outside DONE; consumers must qualify it with out_valid.

Reset
REQ-027 While reset=0 the block SHALL be in IDLE with:
  - col=0, out_valid=0, busy=0, in_ready=0.
  - latched state, enc and result registers all 0.
REQ-028 Reset asserted mid-RUN or mid-DONE SHALL abort immediately and asynchronously, with no output handshake.
REQ-029 After reset deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-030 Macro XC_AESMIX_CTRL_PAR_EN SHALL select the datapath width.
  - Defined: four xc_aesmix instances process all columns in a single RUN cycle, so accept on edge T gives out_valid from edge T+1, and col is unused and held at 0.
  - Undefined: one shared instance processes four serial RUN cycles, per REQ-016 to REQ-018.
REQ-031 Result values and all handshake and flush rules SHALL be identical in both builds; only latency differs.

Verification
REQ-032 Forward known answer:
  - Stimulus: columns 0..3 = 0x455313db, 0x5c220af2, 0x01010101, 0xc6c6c6c6; enc=1.
  - Required: out_state columns = 0xbca14d8e, 0x9d58dc9f, 0x01010101, 0xc6c6c6c6.
  - Required: out_valid exactly 4 cycles after accept (1 cycle with PAR_EN).
REQ-033 Inverse known answer:
  - Stimulus: columns 0xbca14d8e, 0x9d58dc9f, 0xd6d7d5d5, 0xc6c6c6c6; enc=0.
  - Required: out_state columns = 0x455313db, 0x5c220af2, 0xd5d4d4d4, 0xc6c6c6c6.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - Required: out_valid stays 1 and out_state is unchanged.
  - Required: in_ready=0 throughout and a new in_valid is ignored.
  - Then out_ready=1: IDLE next cycle, in_ready=1 the cycle after the handshake.
REQ-035 Flush mid-RUN: assert flush when col==2.
  - Required: IDLE next edge, out_valid never asserted.
  - Required: a following request with an all-0x01010101 state returns 0x01010101 columns.
REQ-036 Asynchronous reset: pulse reset low for less than one clock period during DONE.
  - Required: out_valid and busy fall without waiting for a clock edge, and all registers read 0.
  - Required: in_ready=1 in the first cycle after release.

Source files
------------

// File: rtl/xc_aesmix_ctrl.sv
// AES MixColumns sequencer: accepts a 128-bit state and mixes its four columns.
// Define XC_AESMIX_CTRL_PAR_EN for four parallel mixers (1 RUN cycle) instead of one serial mixer.

module xc_aesmix (
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic        enc,
  input  logic        valid,
  output logic [31:0] result
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [31:0] col;
  logic [7:0]  a0, a1, a2, a3, u, v, t;

  // Low half of the column comes from rs1, high half from rs2.
  assign col = {rs2[31:16], rs1[15:0]} & {32{valid}};

  logic unused_ok;
  assign unused_ok = ^{rs1[31:16], rs2[15:0]};

  always_comb begin
    u  = 8'h00;
    v  = 8'h00;
    if (!enc) begin
      // InvMixColumns = forward mix after this pre-conditioning step.
      u = xt(xt(col[7:0] ^ col[23:16]));
      v = xt(xt(col[15:8] ^ col[31:24]));
    end
    a0 = col[7:0]   ^ u;
    a1 = col[15:8]  ^ v;
    a2 = col[23:16] ^ u;
    a3 = col[31:24] ^ v;
    t  = a0 ^ a1 ^ a2 ^ a3;
    result = {a3 ^ t ^ xt(a3 ^ a0), a2 ^ t ^ xt(a2 ^ a3),
              a1 ^ t ^ xt(a1 ^ a2), a0 ^ t ^ xt(a0 ^ a1)};
  end

endmodule

module xc_aesmix_ctrl (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_enc,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e       state_q, state_d;
  logic [1:0]   col_q, col_d;
  logic         enc_q, enc_d;
  logic [127:0] data_q, data_d;
  logic [127:0] result_q, result_d;
  logic         run;
  logic         accept;

  assign run    = (state_q == StRun);
  assign accept = in_valid & in_ready;

`ifdef XC_AESMIX_CTRL_PAR_EN
  logic [127:0] mix_all;

  for (genvar g = 0; g < 4; g++) begin : g_mix
    xc_aesmix u_mix (
      .rs1    (data_q[32*g +: 32]),
      .rs2    (data_q[32*g +: 32]),
      .enc    (enc_q),
      .valid  (run),
      .result (mix_all[32*g +: 32])
    );
  end
`else
  logic [31:0] mix_in, mix_out;

  assign mix_in = data_q[{col_q, 5'd0} +: 32];

  xc_aesmix u_mix (
    .rs1    (mix_in),
    .rs2    (mix_in),
    .enc    (enc_q),
    .valid  (run),
    .result (mix_out)
  );
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (accept) state_d = StRun;
`ifdef XC_AESMIX_CTRL_PAR_EN
        StRun:  state_d = StDone;
`else
        StRun:  if (col_q == 2'd3) state_d = StDone;
`endif
        StDone: if (out_ready) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // in_ready is also masked by reset so it reads 0 while reset is held.
  always_comb begin
    in_ready  = reset & ~flush & (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q == StRun) | (state_q == StDone);
    out_state = result_q;
  end

  always_comb begin
    col_d    = col_q;
    enc_d    = enc_q;
    data_d   = data_q;
    result_d = result_q;
    if (flush) begin
      col_d = 2'd0;
    end else if (accept) begin
      data_d = in_state;
      enc_d  = in_enc;
      col_d  = 2'd0;
    end else if (run) begin
`ifdef XC_AESMIX_CTRL_PAR_EN
      result_d = mix_all;
`else
      result_d[{col_q, 5'd0} +: 32] = mix_out;
      col_d = col_q + 2'd1;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col_q    <= 2'd0;
      enc_q    <= 1'b0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      col_q    <= col_d;
      enc_q    <= enc_d;
      data_q   <= data_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_xc_aesmix_ctrl.sv
// Directed-vector bench for xc_aesmix_ctrl: known answers, backpressure, flush and async reset.
`timescale 1ns/1ps

module tb_xc_aesmix_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_enc = 1'b0;
  logic [127:0] in_state = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_state;
  logic         busy;

`ifdef XC_AESMIX_CTRL_PAR_EN
  localparam int ExpLat = 1;
`else
  localparam int ExpLat = 4;
`endif

  xc_aesmix_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_enc    (in_enc),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         enc;
    logic [127:0] st;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[4];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and count edges until out_valid (0 if it never came).
  task automatic start_op(input logic enc, input logic [127:0] st, output int lat);
    @(negedge clock);
    in_valid = 1'b1;
    in_enc   = enc;
    in_state = st;
    @(posedge clock);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic handshake();
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock);
    #1 out_ready = 1'b0;
    check("hs_out_valid", {127'd0, out_valid}, 128'd0);
    check("hs_in_ready", {127'd0, in_ready}, 128'd1);
    check("hs_busy", {127'd0, busy}, 128'd0);
  endtask

  initial begin
    int lat;
    logic seen;

    vecs[0] = '{1'b1, {32'hc6c6c6c6, 32'h01010101, 32'h5c220af2, 32'h455313db},
                      {32'hc6c6c6c6, 32'h01010101, 32'h9d58dc9f, 32'hbca14d8e}};
    vecs[1] = '{1'b0, {32'hc6c6c6c6, 32'hd6d7d5d5, 32'h9d58dc9f, 32'hbca14d8e},
                      {32'hc6c6c6c6, 32'hd5d4d4d4, 32'h5c220af2, 32'h455313db}};
    vecs[2] = '{1'b1, {32'h4c31262d, 32'hd5d4d4d4, 32'h00000000, 32'hffffffff},
                      {32'hf8bd7e4d, 32'hd6d7d5d5, 32'h00000000, 32'hffffffff}};
    vecs[3] = '{1'b0, {32'hf8bd7e4d, 32'hd6d7d5d5, 32'h00000000, 32'h12121212},
                      {32'h4c31262d, 32'hd5d4d4d4, 32'h00000000, 32'h12121212}};

    // Reset state
    #12;
    check("rst_in_ready", {127'd0, in_ready}, 128'd0);
    check("rst_out_valid", {127'd0, out_valid}, 128'd0);
    check("rst_busy", {127'd0, busy}, 128'd0);
    check("rst_out_state", out_state, 128'd0);
    @(negedge clock);
    reset = 1'b1;
    #1 check("post_rst_in_ready", {127'd0, in_ready}, 128'd1);

    // Known-answer table
    for (int i = 0; i < 4; i++) begin
      start_op(vecs[i].enc, vecs[i].st, lat);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(ExpLat));
      check($sformatf("vec%0d_result", i), out_state, vecs[i].exp);
      handshake();
    end

    // Backpressure in DONE with a competing request
    start_op(vecs[0].enc, vecs[0].st, lat);
    check("bp_latency", 128'(lat), 128'(ExpLat));
    @(negedge clock);
    in_valid = 1'b1;
    in_enc   = 1'b0;
    in_state = {4{32'h01010101}};
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      check("bp_out_valid", {127'd0, out_valid}, 128'd1);
      check("bp_out_state", out_state, vecs[0].exp);
      check("bp_in_ready", {127'd0, in_ready}, 128'd0);
    end
    @(negedge clock);
    in_valid = 1'b0;
    handshake();

    // Flush while column 2 is being mixed
    @(negedge clock);
    in_valid = 1'b1;
    in_enc   = 1'b1;
    in_state = vecs[0].st;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (ExpLat - 2 > 0 ? 2 : 0) @(posedge clock);
    #1 flush = 1'b1;
    check("flush_in_ready", {127'd0, in_ready}, 128'd0);
    @(posedge clock);
    #1 flush = 1'b0;
    check("flush_busy", {127'd0, busy}, 128'd0);
    seen = out_valid;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1 seen |= out_valid;
    end
    check("flush_no_out_valid", {127'd0, seen}, 128'd0);

    // Flush beats a simultaneous request
    @(negedge clock);
    flush    = 1'b1;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_vs_accept_busy", {127'd0, busy}, 128'd0);

    start_op(1'b1, {4{32'h01010101}}, lat);
    check("after_flush_latency", 128'(lat), 128'(ExpLat));
    check("after_flush_result", out_state, {4{32'h01010101}});
    handshake();

    // Short asynchronous reset pulse while in DONE
    start_op(vecs[1].enc, vecs[1].st, lat);
    check("ar_pre_valid", {127'd0, out_valid}, 128'd1);
    @(negedge clock);
    #1 reset = 1'b0;
    #1;
    check("ar_out_valid", {127'd0, out_valid}, 128'd0);
    check("ar_busy", {127'd0, busy}, 128'd0);
    check("ar_out_state", out_state, 128'd0);
    #1 reset = 1'b1;
    #1 check("ar_release_in_ready", {127'd0, in_ready}, 128'd1);
    @(posedge clock);
    #1 check("ar_first_cycle_in_ready", {127'd0, in_ready}, 128'd1);

    start_op(vecs[2].enc, vecs[2].st, lat);
    check("ar_after_latency", 128'(lat), 128'(ExpLat));
    check("ar_after_result", out_state, vecs[2].exp);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
